// File: rtl/mac_result_writeback_if.sv
// Bundle of handshake and data signals between the FMA round stage, the
// result writeback block and the register-file writeback port.
//   Upstream side : Valid_i/Ready_o, Sign_i, Exp_i, Mant_i, Tag_i, raw flags,
//                   Inf_operand_i, Flush_i
//   Downstream    : Valid_o/Ready_i, Result_o, Tag_o, Fflags_o
//   CSR side      : Fflags_acc_o, Fflags_clr_i
//   Status        : Busy_o
// slave  = view of the writeback block itself
// master = view of the surrounding pipeline / environment
interface mac_result_writeback_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 5
);
  logic                 Valid_i;
  logic                 Ready_o;
  logic                 Sign_i;
  logic [PARM_EXP-1:0]  Exp_i;
  logic [PARM_MANT-1:0] Mant_i;
  logic [PARM_TAG-1:0]  Tag_i;
  logic                 Invalid_i;
  logic                 Overflow_i;
  logic                 Underflow_i;
  logic                 Inexact_i;
  logic                 Inf_operand_i;
  logic                 Flush_i;
  logic                 Valid_o;
  logic                 Ready_i;
  logic [31:0]          Result_o;
  logic [PARM_TAG-1:0]  Tag_o;
  logic [4:0]           Fflags_o;
  logic [4:0]           Fflags_acc_o;
  logic                 Fflags_clr_i;
  logic                 Busy_o;

  modport slave (
    input  Valid_i, Sign_i, Exp_i, Mant_i, Tag_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i, Inf_operand_i,
           Flush_i, Ready_i, Fflags_clr_i,
    output Ready_o, Valid_o, Result_o, Tag_o, Fflags_o, Fflags_acc_o, Busy_o
  );

  modport master (
    output Valid_i, Sign_i, Exp_i, Mant_i, Tag_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i, Inf_operand_i,
           Flush_i, Ready_i, Fflags_clr_i,
    input  Ready_o, Valid_o, Result_o, Tag_o, Fflags_o, Fflags_acc_o, Busy_o
  );
endinterface

// File: rtl/mac_result_writeback.sv
// FMA result writeback stage.
// Packs the rounded sign/exponent/mantissa into a binary32 word (canonical
// NaN substitution), qualifies raw exception flags into fflags {NV,DZ,OF,UF,NX},
// buffers results in a small circular FIFO towards the register-file
// writeback port, and keeps a sticky fflags accumulator for the CSR.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   wb     : mac_result_writeback_if.slave (upstream, downstream, CSR, status)
module mac_result_writeback #(
  parameter int          PARM_EXP   = 8,
  parameter int          PARM_MANT  = 23,
  parameter int          PARM_TAG   = 5,
  parameter int          PARM_DEPTH = 2,
  parameter logic [31:0] PARM_NAN   = 32'h7FC0_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mac_result_writeback_if.slave wb
);

  localparam int PTR_W = $clog2(PARM_DEPTH);

  // NaN substitution: invalid operations and any incoming NaN encoding
  // collapse to the single canonical quiet NaN.
  function automatic logic [31:0] pack_result(
    input logic                 sign,
    input logic [PARM_EXP-1:0]  exp_v,
    input logic [PARM_MANT-1:0] mant_v,
    input logic                 inv
  );
    if (inv || ((&exp_v) && (|mant_v)))
      return PARM_NAN;
    return {sign, exp_v, mant_v};
  endfunction

  // Overflow only counts when the rounded result really is infinity and no
  // operand was already infinite; underflow needs tininess plus inexact.
  function automatic logic [4:0] qualify_flags(
    input logic [PARM_EXP-1:0]  exp_v,
    input logic [PARM_MANT-1:0] mant_v,
    input logic                 inv,
    input logic                 ovf,
    input logic                 unf,
    input logic                 inx,
    input logic                 inf_op
  );
    logic of_q, uf_q, nx_q;
    of_q = ovf & ~inv & ~inf_op & (&exp_v) & ~(|mant_v);
    uf_q = unf & inx & ~inv;
    nx_q = (inx | of_q) & ~inv;
    return {inv, 1'b0, of_q, uf_q, nx_q};
  endfunction

  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic [PTR_W-1:0]   wr_idx, rd_idx;
  logic               full, empty, push, pop;
  logic [31:0]        result_p0;
  logic [4:0]         flags_p0;
  logic [31:0]        res_mem_p1  [PARM_DEPTH];
  logic [PARM_TAG-1:0] tag_mem_p1 [PARM_DEPTH];
  logic [4:0]         flag_mem_p1 [PARM_DEPTH];
  logic [4:0]         head_flags;
  logic [4:0]         fflags_acc, acc_next;

  // ---- stage p0: enqueue-side packing and qualification
  assign result_p0 = pack_result(wb.Sign_i, wb.Exp_i, wb.Mant_i, wb.Invalid_i);
  assign flags_p0  = qualify_flags(wb.Exp_i, wb.Mant_i, wb.Invalid_i,
                                   wb.Overflow_i, wb.Underflow_i,
                                   wb.Inexact_i, wb.Inf_operand_i);

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  // A flush swallows any push offered in the same cycle.
  assign push   = wb.Valid_i & ~full & ~wb.Flush_i;
  assign pop    = ~empty & wb.Ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (wb.Flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- stage p1: FIFO storage (data only, no reset)
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem_p1[wr_idx]  <= result_p0;
      tag_mem_p1[wr_idx]  <= wb.Tag_i;
      flag_mem_p1[wr_idx] <= flags_p0;
    end
  end

  // Outputs are read straight from storage and forced to zero when empty so
  // the downstream port never sees stale entries.
  assign head_flags  = empty ? '0 : flag_mem_p1[rd_idx];
  assign wb.Valid_o  = ~empty;
  assign wb.Busy_o   = ~empty;
  assign wb.Ready_o  = ~full;
  assign wb.Result_o = empty ? '0 : res_mem_p1[rd_idx];
  assign wb.Tag_o    = empty ? '0 : tag_mem_p1[rd_idx];
  assign wb.Fflags_o = head_flags;

  // Flags popped in a clear cycle are kept so no exception is lost.
  always_comb begin
    acc_next = fflags_acc;
    if (wb.Fflags_clr_i)
      acc_next = pop ? head_flags : '0;
    else if (pop)
      acc_next = fflags_acc | head_flags;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags_acc <= '0;
    else         fflags_acc <= acc_next;
  end

  assign wb.Fflags_acc_o = fflags_acc;

endmodule

// File: doc/mac_result_writeback.md
Name: mac_result_writeback

Overview:
- Output stage directly downstream of the FMA normalize/round stage.
- Captures the rounded sign/exponent/mantissa and raw exception flags each valid cycle and packs them into an IEEE-754 binary32 word with a canonical NaN.
- Qualifies the flags to RISC-V fflags semantics, buffers results in a small FIFO with a valid/ready handshake to the register-file writeback port, and keeps a sticky fflags accumulator for the CSR.

Parameters:
PARM_EXP, 8, exponent width
PARM_MANT, 23, stored mantissa width
PARM_TAG, 5, destination-register tag width
PARM_DEPTH, 2, result FIFO depth (power of two, >=2)
PARM_NAN, 32'h7FC0_0000, canonical quiet NaN

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  reset, asynchronous, active-low
Valid_i  in  1  upstream result valid
Ready_o  out  1  FIFO can accept (not full)
Sign_i  in  1  rounded sign
Exp_i  in  PARM_EXP  rounded biased exponent
Mant_i  in  PARM_MANT  rounded fraction
Tag_i  in  PARM_TAG  destination register
Invalid_i  in  1  raw invalid flag
Overflow_i  in  1  raw overflow flag
Underflow_i  in  1  raw underflow flag
Inexact_i  in  1  raw inexact flag
Inf_operand_i  in  1  any operand was infinity
Flush_i  in  1  synchronous pipeline flush
Valid_o  out  1  head result valid
Ready_i  in  1  writeback port accepts
Result_o  out  32  packed binary32
Tag_o  out  PARM_TAG  head tag
Fflags_o  out  5  head flags {NV,DZ,OF,UF,NX}
Fflags_acc_o  out  5  sticky accumulated fflags
Fflags_clr_i  in  1  clear accumulator
Busy_o  out  1  FIFO non-empty

Behaviour:
- Reset (rst_ni=0, asynchronous): FIFO empty; Valid_o=0; Busy_o=0; Result_o, Tag_o, Fflags_o = 0; Fflags_acc_o=0; Ready_o=1 once reset is released.
- Accept when Valid_i & Ready_o. Pop when Valid_o & Ready_i. Ready_o = ~full; it does not depend combinationally on Ready_i.
- Latency: an accepted entry appears on Valid_o the next cycle. Output is registered from FIFO storage (no combinational pass-through).
- Packing:
  - If Invalid_i, or (Exp_i all-ones and Mant_i != 0): Result = PARM_NAN.
  - Otherwise Result = {Sign_i, Exp_i, Mant_i}.
- Flag qualification, computed at enqueue:
  - NV = Invalid_i.
  - DZ = 0.
  - OF = Overflow_i & ~Invalid_i & ~Inf_operand_i & (Exp_i all-ones) & (Mant_i == 0).
  - UF = Underflow_i & Inexact_i & ~Invalid_i.
  - NX = (Inexact_i | OF) & ~Invalid_i.
- FIFO:
  - Circular buffer of PARM_DEPTH entries; read/write pointers have one extra wrap bit.
  - Full when the low pointer bits are equal and the wrap bits differ.
  - Pointers wrap modulo PARM_DEPTH.
  - Simultaneous push and pop when full is legal only if Ready_o=1, so no push happens when full.
  - Simultaneous push and pop when non-empty keeps the occupancy unchanged.
  - Push attempted when full: ignored; upstream must hold its data.
- Accumulator:
  - On pop: Fflags_acc <= Fflags_acc | Fflags_o.
  - Fflags_clr_i alone: Fflags_acc <= 0.
  - Clear and pop in the same cycle: Fflags_acc <= Fflags_o (the popped flags survive the clear).
- Flush_i: empties the FIFO next cycle and drops any same-cycle push. Pops in the flush cycle still count (Valid_o/Ready_i). The accumulator is otherwise untouched.
- Reset asserted mid-transfer: all entries are lost immediately and the accumulator clears.
- Busy_o = FIFO non-empty.

Test Plan:
- Reset: hold rst_ni=0, drive Valid_i=1 -> Valid_o=0, Fflags_acc_o=0, Ready_o=1 after release, no entry captured.
- Single normal result: Sign=0, Exp=8'h7F, Mant=0, Inexact=1, Ready_i=1 -> next cycle Valid_o=1, Result_o=32'h3F80_0000, Fflags_o=5'b00001; after the pop, Fflags_acc_o=5'b00001.
- NaN/overflow qualification:
  - Invalid=1 with Exp=8'hFF, Mant=0 -> Result_o=32'h7FC0_0000, Fflags_o=5'b10000.
  - Overflow=1, Inf_operand=1, Exp=8'hFF, Mant=0 -> Result_o=32'h7F80_0000, Fflags_o=5'b00000.
  - Overflow=1, Inf_operand=0 -> Fflags_o=5'b00101.
- Backpressure: Ready_i=0, push 3 results -> Ready_o=0 after 2; third held; Ready_i=1 -> drained in order with correct tags; Busy_o drops after the last pop.
- Accumulator race: Fflags_clr_i=1 in the same cycle as popping flags 5'b00011 -> Fflags_acc_o=5'b00011; a clear-only cycle -> 0.
- Flush: 2 entries queued, Flush_i=1 with a simultaneous push -> next cycle Valid_o=0, Busy_o=0, Ready_o=1, Fflags_acc_o unchanged.
